// File: rtl/dog_motion_ctrl.sv
// dog_motion_ctrl: frame-synchronous motion and animation sequencer for the
// dog sprite. Commands (stop/walk/jump/sit) select a behaviour. Position and
// animation advance only on frame_start pulses, so the sprite never tears
// mid-scan.
module dog_motion_ctrl #(
    parameter int SCREEN_W        = 640,
    parameter int DOG_W           = 64,
    parameter int GROUND_Y        = 300,
    parameter int JUMP_H          = 64,
    parameter int STEP            = 4,
    parameter int FRAMES_PER_ANIM = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic [9:0] DogPos_x,
    output logic [9:0] DogPos_y,
    output logic [2:0] ActionSel,
    output logic       busy
);

    localparam int ANIM_W = (FRAMES_PER_ANIM > 1) ? $clog2(FRAMES_PER_ANIM) : 1;

    localparam logic [9:0]        X_MAX     = 10'(SCREEN_W - DOG_W);
    localparam logic [9:0]        STEP_V    = 10'(STEP);
    localparam logic [9:0]        GROUND_V  = 10'(GROUND_Y);
    localparam logic [9:0]        Y_APEX    = 10'(GROUND_Y - JUMP_H);
    localparam logic [9:0]        Y_TURN    = 10'(GROUND_Y - JUMP_H + STEP);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(FRAMES_PER_ANIM - 1);

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_WALK = 2'b01;
    localparam logic [1:0] CMD_JUMP = 2'b10;
    localparam logic [1:0] CMD_SIT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        SIT,
        JUMP_UP,
        JUMP_DOWN
    } StateT;

    StateT             state, stateNext;
    logic              dir, dirNext;
    logic              phase, phaseNext;
    logic              retWalk, retWalkNext;
    logic [ANIM_W-1:0] animCnt, animNext;
    logic [9:0]        xNext, yNext;
    logic [10:0]       xSum;
    logic              moveX;
    logic              inJump;

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            DogPos_x <= '0;
            DogPos_y <= GROUND_V;
            dir      <= 1'b0;
            phase    <= 1'b0;
            animCnt  <= '0;
            retWalk  <= 1'b0;
        end else begin
            state    <= stateNext;
            DogPos_x <= xNext;
            DogPos_y <= yNext;
            dir      <= dirNext;
            phase    <= phaseNext;
            animCnt  <= animNext;
            retWalk  <= retWalkNext;
        end
    end

    // Next-state logic: the frame step acts on the old state, then an accepted command picks the new state.
    always_comb begin
        stateNext   = state;
        xNext       = DogPos_x;
        yNext       = DogPos_y;
        dirNext     = dir;
        phaseNext   = phase;
        animNext    = animCnt;
        retWalkNext = retWalk;
        xSum        = {1'b0, DogPos_x} + {1'b0, STEP_V};
        moveX       = (state == WALK) ||
                      (retWalk && ((state == JUMP_UP) || (state == JUMP_DOWN)));

        if (frame_start) begin
            if (moveX) begin
                if (!dir) begin
                    if (xSum >= {1'b0, X_MAX}) begin
                        xNext   = X_MAX;
                        dirNext = 1'b1;
                    end else begin
                        xNext = xSum[9:0];
                    end
                end else begin
                    if (DogPos_x < STEP_V) begin
                        xNext   = '0;
                        dirNext = 1'b0;
                    end else begin
                        xNext = DogPos_x - STEP_V;
                    end
                end
            end

            case (state)
                WALK: begin
                    if (animCnt == ANIM_LAST) begin
                        animNext  = '0;
                        phaseNext = ~phase;
                    end else begin
                        animNext = animCnt + ANIM_W'(1);
                    end
                end
                JUMP_UP: begin
                    if (DogPos_y <= Y_TURN) begin
                        yNext     = Y_APEX;
                        stateNext = JUMP_DOWN;
                    end else begin
                        yNext = DogPos_y - STEP_V;
                    end
                end
                JUMP_DOWN: begin
                    if (DogPos_y + STEP_V >= GROUND_V) begin
                        yNext     = GROUND_V;
                        stateNext = retWalk ? WALK : IDLE;
                    end else begin
                        yNext = DogPos_y + STEP_V;
                    end
                end
                default: begin
                end
            endcase
        end

        if (cmd_valid && cmd_ready) begin
            case (cmd)
                CMD_STOP: stateNext = IDLE;
                CMD_WALK: begin
                    stateNext = WALK;
                    animNext  = '0;
                    phaseNext = 1'b0;
                end
                CMD_JUMP: begin
                    stateNext   = JUMP_UP;
                    retWalkNext = (state == WALK);
                end
                CMD_SIT:  stateNext = SIT;
                default:  stateNext = state;
            endcase
        end
    end

    // Handshake, busy flag and sprite action are decoded from the registered state.
    always_comb begin
        inJump    = (state == JUMP_UP) || (state == JUMP_DOWN);
        cmd_ready = !inJump;
        busy      = inJump;
        ActionSel = 3'd0;
        case (state)
            WALK:      ActionSel = dir ? (3'd3 + {2'b00, phase}) : (3'd1 + {2'b00, phase});
            SIT:       ActionSel = 3'd6;
            JUMP_UP:   ActionSel = 3'd5;
            JUMP_DOWN: ActionSel = 3'd5;
            default:   ActionSel = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_dog_motion_ctrl.sv
// tb_dog_motion_ctrl: table-driven vectors plus directed multi-cycle
// sequences for walking, boundary turns, jumps and reset at jump apex.
module tb_dog_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frameStart = 1'b0;
    logic       cmdValid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmdReady;
    logic [9:0] dogX;
    logic [9:0] dogY;
    logic [2:0] actionSel;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       rst;
        logic       fs;
        logic       cv;
        logic [1:0] cmd;
        int         x;
        int         y;
        int         sel;
        int         rdy;
        int         bsy;
    } VecT;

    VecT vecs[14];

    dog_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frameStart),
        .cmd_valid  (cmdValid),
        .cmd        (cmd),
        .cmd_ready  (cmdReady),
        .DogPos_x   (dogX),
        .DogPos_y   (dogY),
        .ActionSel  (actionSel),
        .busy       (busy)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then return #1 after the active edge with pulses cleared.
    task automatic applyStimulus(input logic r, input logic fs, input logic cv, input logic [1:0] c);
        @(negedge clk);
        rst        = r;
        frameStart = fs;
        cmdValid   = cv;
        cmd        = c;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        frameStart = 1'b0;
        cmdValid   = 1'b0;
        cmd        = 2'b00;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        assertCount++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input int x, input int y, input int sel,
                            input int rdy, input int bsy);
        checkOutput({name, ".x"}, int'(dogX), x);
        checkOutput({name, ".y"}, int'(dogY), y);
        checkOutput({name, ".sel"}, int'(actionSel), sel);
        checkOutput({name, ".ready"}, int'(cmdReady), rdy);
        checkOutput({name, ".busy"}, int'(busy), bsy);
    endtask

    // One frame pulse followed by a quiet cycle.
    task automatic pulseFrame();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        // rst fs cv cmd   x   y  sel rdy bsy
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00,  0, 300, 0, 1, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00,  0, 300, 0, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b01,  0, 300, 1, 1, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00,  4, 300, 1, 1, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b00,  8, 300, 1, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b00, 12, 300, 0, 1, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b00, 12, 300, 0, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b11, 12, 300, 6, 1, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b00, 12, 300, 6, 1, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b01, 12, 300, 1, 1, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b10, 16, 300, 5, 0, 1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b00, 20, 296, 5, 0, 1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 2'b11, 24, 292, 5, 0, 1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 2'b01,  0, 300, 0, 1, 0};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fs, vecs[i].cv, vecs[i].cmd);
            checkAll($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].sel,
                     vecs[i].rdy, vecs[i].bsy);
        end

        // Walk from reset: x advances 4 per frame, phase flips every 8 frames.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
        for (int i = 1; i <= 16; i++) begin
            pulseFrame();
            checkOutput($sformatf("walk%0d.x", i), int'(dogX), 4 * i);
            checkOutput($sformatf("walk%0d.sel", i), int'(actionSel), ((i / 8) % 2) + 1);
        end
        checkOutput("walk.y", int'(dogY), 300);

        // Right boundary at 576, then left boundary at 0.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 142; i++) pulseFrame();
        checkOutput("edgeR.start", int'(dogX), 568);
        pulseFrame();
        checkOutput("edgeR.572", int'(dogX), 572);
        checkOutput("edgeR.572sel", (actionSel == 3'd1 || actionSel == 3'd2) ? 1 : 0, 1);
        pulseFrame();
        checkOutput("edgeR.576", int'(dogX), 576);
        checkOutput("edgeR.turnsel", (actionSel == 3'd3 || actionSel == 3'd4) ? 1 : 0, 1);
        pulseFrame();
        checkOutput("edgeR.back", int'(dogX), 572);
        for (int i = 0; i < 142; i++) pulseFrame();
        checkOutput("edgeL.start", int'(dogX), 4);
        pulseFrame();
        checkOutput("edgeL.0", int'(dogX), 0);
        checkOutput("edgeL.0sel", (actionSel == 3'd3 || actionSel == 3'd4) ? 1 : 0, 1);
        pulseFrame();
        checkOutput("edgeL.clamp", int'(dogX), 0);
        checkOutput("edgeL.turnsel", (actionSel == 3'd1 || actionSel == 3'd2) ? 1 : 0, 1);
        pulseFrame();
        checkOutput("edgeL.4", int'(dogX), 4);

        // Jump from IDLE: 16 frames up, 16 down, back to IDLE.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10);
        checkAll("jumpIdle.start", 0, 300, 5, 0, 1);
        for (int i = 1; i <= 32; i++) begin
            pulseFrame();
            checkOutput($sformatf("jumpIdle%0d.y", i), int'(dogY),
                        (i <= 16) ? (300 - 4 * i) : (236 + 4 * (i - 16)));
            if (i < 32) checkOutput($sformatf("jumpIdle%0d.busy", i), int'(busy), 1);
        end
        checkAll("jumpIdle.end", 0, 300, 0, 1, 0);

        // Jump while walking right at x=100, sit command ignored mid-jump.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 25; i++) pulseFrame();
        checkOutput("jumpWalk.x0", int'(dogX), 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10);
        checkAll("jumpWalk.start", 100, 300, 5, 0, 1);
        for (int i = 1; i <= 32; i++) begin
            if (i == 10) begin
                applyStimulus(1'b0, 1'b1, 1'b1, 2'b11);
                applyStimulus(1'b0, 1'b0, 1'b1, 2'b11);
                checkOutput("jumpWalk.sitIgnored", int'(actionSel), 5);
            end else begin
                pulseFrame();
            end
        end
        checkOutput("jumpWalk.x", int'(dogX), 228);
        checkOutput("jumpWalk.y", int'(dogY), 300);
        checkOutput("jumpWalk.sel", (actionSel == 3'd1 || actionSel == 3'd2) ? 1 : 0, 1);
        checkOutput("jumpWalk.ready", int'(cmdReady), 1);
        pulseFrame();
        checkOutput("jumpWalk.resume", int'(dogX), 232);

        // Sit in the same cycle as frame_start while walking at x=40.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 10; i++) pulseFrame();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11);
        checkAll("sitFrame", 44, 300, 6, 1, 0);
        pulseFrame();
        pulseFrame();
        checkOutput("sitFrame.hold", int'(dogX), 44);

        // Reset at jump apex while walking, with other inputs asserted.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 5; i++) pulseFrame();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 16; i++) pulseFrame();
        checkOutput("apex.y", int'(dogY), 236);
        checkOutput("apex.x", int'(dogX), 84);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b01);
        checkAll("apexReset", 0, 300, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
